distance_arbiter: RTL

Round-robin arbiter and sequencer that shares one `distance` unit (squared-Euclidean, serial per-dimension subtract and shift-add square) among `NUM_REQ` requesters. It accepts one vertex/query job at a time and replays the coordinates into the unit with the per-dimension valid pattern the unit expects. It waits for the result and returns it tagged with the requester ID. It sits between the vertex-fetch/query front-ends and the single distance datapath instance in the search core.

---
 rtl/distance_arbiter_if.sv | 28 ++
 rtl/distance_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/distance_arbiter_if.sv
// Requester/response bus of distance_arbiter.
// master: vertex-fetch/query front-end side; slave: the arbiter.
interface distance_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DIM     = 2
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid_in;
    logic [NUM_REQ-1:0]        req_ready_out;
    logic [NUM_REQ*DIM*32-1:0] req_vertex_in;
    logic [NUM_REQ*DIM*32-1:0] req_query_in;
    logic                      resp_valid_out;
    logic                      resp_ready_in;
    logic [ID_W-1:0]           resp_id_out;
    logic [31:0]               resp_distance_out;
    logic                      resp_error_out;

    modport master (
        output req_valid_in, req_vertex_in, req_query_in, resp_ready_in,
        input  req_ready_out, resp_valid_out, resp_id_out, resp_distance_out, resp_error_out
    );

    modport slave (
        input  req_valid_in, req_vertex_in, req_query_in, resp_ready_in,
        output req_ready_out, resp_valid_out, resp_id_out, resp_distance_out, resp_error_out
    );
endinterface

// File: rtl/distance_arbiter.sv
// Round-robin arbiter/sequencer sharing one serial squared-distance unit among
// NUM_REQ requesters. One job in flight: grant, replay operands for DIM cycles,
// wait for the unit result, hold the tagged response until accepted.
// Optional WAIT watchdog: define DIST_ARB_TIMEOUT_EN.
module distance_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned DIM            = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    distance_arbiter_if.slave      bus,
    output logic [DIM-1:0]         dist_valid_out,
    output logic [DIM*32-1:0]      dist_vertex_out,
    output logic [DIM*32-1:0]      dist_query_out,
    output logic                   dist_rst_out,
    input  logic [31:0]            dist_result_in,
    input  logic                   dist_valid_in
);
    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned IC_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int unsigned OP_W = DIM * 32;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [ID_W-1:0]    id_q;
    logic [OP_W-1:0]    vertex_q;
    logic [OP_W-1:0]    query_q;
    logic [IC_W-1:0]    issue_cnt_q;
    logic [DIM-1:0]     dist_valid_q;
    logic               dist_rst_q;
    logic               resp_valid_q;
    logic               resp_error_q;
    logic [31:0]        resp_dist_q;

    logic               hit_hi, hit_lo;
    logic [ID_W-1:0]    g_hi, g_lo;
    logic               grant_hit_d;
    logic [ID_W-1:0]    grant_d;
    logic               accept;
    logic [NUM_REQ-1:0] ready_d;
    logic [OP_W-1:0]    vert_sel_d;
    logic [OP_W-1:0]    query_sel_d;

`ifdef DIST_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0]      wait_cnt_q;
`else
    // Watchdog compiled out; parameter kept so instantiations are identical.
    logic [31:0]        unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
`endif

    // Round-robin search from last_grant+1: first valid above last_grant, else lowest valid.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        g_hi   = '0;
        g_lo   = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (bus.req_valid_in[r]) begin
                if (!hit_hi && (ID_W'(r) > last_grant_q)) begin
                    hit_hi = 1'b1;
                    g_hi   = ID_W'(r);
                end
                if (!hit_lo) begin
                    hit_lo = 1'b1;
                    g_lo   = ID_W'(r);
                end
            end
        end
        grant_hit_d = hit_lo;
        grant_d     = hit_hi ? g_hi : g_lo;
    end

    // No grant while the unit is still held in reset.
    assign accept = (state_q == S_IDLE) && !dist_rst_q && grant_hit_d;

    // One-hot ready and operand mux for the granted requester.
    always_comb begin
        ready_d     = '0;
        vert_sel_d  = '0;
        query_sel_d = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (ID_W'(r) == grant_d) begin
                ready_d[r]  = accept;
                vert_sel_d  = bus.req_vertex_in[r*OP_W +: OP_W];
                query_sel_d = bus.req_query_in[r*OP_W +: OP_W];
            end
        end
    end

    // Job sequencer FSM with registered unit and response outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= S_IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            vertex_q     <= '0;
            query_q      <= '0;
            issue_cnt_q  <= '0;
            dist_valid_q <= '0;
            dist_rst_q   <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_dist_q  <= '0;
`ifdef DIST_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            dist_rst_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        vertex_q     <= vert_sel_d;
                        query_q      <= query_sel_d;
                        last_grant_q <= grant_d;
                        id_q         <= grant_d;
                        issue_cnt_q  <= '0;
                        dist_valid_q <= '1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue_cnt_q == IC_W'(DIM - 1)) begin
                        dist_valid_q <= '0;
                        state_q      <= S_WAIT;
`ifdef DIST_ARB_TIMEOUT_EN
                        wait_cnt_q   <= '0;
`endif
                    end else begin
                        issue_cnt_q <= issue_cnt_q + IC_W'(1);
                    end
                end
                S_WAIT: begin
                    if (dist_valid_in) begin
                        resp_dist_q  <= dist_result_in;
                        resp_error_q <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
`ifdef DIST_ARB_TIMEOUT_EN
                    else if (wait_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        dist_rst_q   <= 1'b1;
                        resp_dist_q  <= '0;
                        resp_error_q <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + TW'(1);
                    end
`endif
                end
                S_RESP: begin
                    if (bus.resp_ready_in) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready_out     = ready_d;
    assign bus.resp_valid_out    = resp_valid_q;
    assign bus.resp_id_out       = id_q;
    assign bus.resp_distance_out = resp_dist_q;
    assign bus.resp_error_out    = resp_error_q;
    assign dist_valid_out        = dist_valid_q;
    assign dist_vertex_out       = vertex_q;
    assign dist_query_out        = query_q;
    assign dist_rst_out          = dist_rst_q;
endmodule
